// File: rtl/trng_bram_pkg.sv
// Shared types and helpers for the BRAM drain reader: FSM states, word size, FIFO sizing.
package trng_bram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        DONE,
        WAIT_CLR
    } rd_state_t;

    localparam int BYTES_PER_WORD = 4;

    // One slot per cycle of read latency plus one, so reads can stream back to back.
    function automatic int fifo_depth_for(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO built as a shift register so the head is always slot 0,
// which makes the head a plain register that holds still while nothing pops.
module bram_rd_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] slots      [DEPTH];
    logic [DW-1:0] slots_next [DEPTH];
    logic          do_pop;
    logic          do_push;
    int            wr_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[0];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        slots_next = slots;
        wr_idx     = do_pop ? int'(count) - 1 : int'(count);
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slots_next[i] = slots[i + 1];
            end
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == wr_idx) begin
                    slots_next[i] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            slots <= '{default: '0};
        end else begin
            count <= count + CW'(do_push) - CW'(do_pop);
            slots <= slots_next;
        end
    end

endmodule

// File: rtl/bram_drain_reader.sv
// Drains a full BRAM in address order onto a valid/ready stream, pacing reads
// with credits so returning data always has a FIFO slot waiting for it.
module bram_drain_reader
    import trng_bram_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int BRAM_DEPTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bram_full,
    output logic          bram_rst,
    output logic          bram_clk,
    output logic          bram_en,
    output logic [3:0]    bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          drain_done,
    output logic          busy
);

    localparam int FIFO_DEPTH = fifo_depth_for(RD_LAT);
    localparam int FCW        = $clog2(FIFO_DEPTH + 1);
    localparam int WCW        = $clog2(BRAM_DEPTH) + 1;
    localparam int IW         = WCW - 1;

    rd_state_t         state, state_next;
    logic [WCW-1:0]    issue_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [RD_LAT-1:0] tag;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              last_issue;
    logic              has_credit;

    assign bram_rst  = rst;
    assign bram_clk  = clk;
    assign bram_we   = 4'b0000;
    assign bram_din  = '0;
    assign bram_addr = AW'(issue_cnt[IW-1:0]) * AW'(BYTES_PER_WORD);

    assign m_tvalid   = !fifo_empty;
    assign accept     = m_tvalid && m_tready;
    assign m_tlast    = m_tvalid && (word_cnt == WCW'(BRAM_DEPTH - 1));
    // A slot freed by this cycle's pop counts, otherwise full-rate streaming would stall.
    assign has_credit = (int'(fifo_count) + $countones(tag) - int'(accept)) < FIFO_DEPTH;
    assign last_issue = bram_en && (issue_cnt == WCW'(BRAM_DEPTH - 1));

    always_comb begin
        state_next = state;
        bram_en    = 1'b0;
        drain_done = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:     if (bram_full) state_next = READ;
            READ: begin
                bram_en = has_credit;
                if (last_issue) state_next = DRAIN;
            end
            DRAIN:    if (accept && m_tlast) state_next = DONE;
            DONE: begin
                drain_done = 1'b1;
                state_next = WAIT_CLR;
            end
            WAIT_CLR: if (!bram_full) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            word_cnt  <= '0;
            tag       <= '0;
        end else begin
            state  <= state_next;
            tag[0] <= bram_en;
            for (int i = 1; i < RD_LAT; i++) begin
                tag[i] <= tag[i - 1];
            end
            if (state == IDLE) begin
                issue_cnt <= '0;
                word_cnt  <= '0;
            end else begin
                if (bram_en) issue_cnt <= issue_cnt + WCW'(1);
                if (accept)  word_cnt  <= word_cnt + WCW'(1);
            end
            assert (!(tag[RD_LAT-1] && fifo_full && !accept));
        end
    end

    // Returning data is captured in the cycle its tag leaves the delay line.
    bram_rd_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag[RD_LAT-1]),
        .din   (bram_dout),
        .pop   (accept),
        .head  (m_tdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
